tb_seq_ctrl: RTL and testbench

TB_SEQ_CTRL -- requirements
Module: tb_seq_ctrl

---
 rtl/tb_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_tb_seq_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_ctrl
//  Purpose  : Self-test sequencer. For each iteration it resets the DUT,
//             issues a start pulse and waits for done, error or a timeout.
//             Every output is registered.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_ctrl #(
  parameter int unsigned RST_CYC = 2,    // DUT reset-low cycles per iteration (1..255)
  parameter int unsigned TIMEOUT = 1000, // max WAIT cycles per iteration (2..65535)
  parameter int unsigned N_ITER  = 4     // iterations per run (1..255)
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       i_go,
  input  logic       i_dut_done,
  input  logic       i_dut_err,
  output logic       o_dut_rstn,
  output logic       o_dut_start,
  output logic       o_busy,
  output logic       o_pass,
  output logic       o_fail,
  output logic       o_timeout,
  output logic [7:0] o_iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [7:0]  C_RST_LAST = 8'(RST_CYC - 1);
  localparam logic [15:0] C_TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  C_N_ITER   = 8'(N_ITER);

  state_t      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [15:0] timer_q, timer_d;
  logic [7:0]  iter_cnt_q, iter_cnt_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        timeout_q, timeout_d;
  logic        dut_rstn_q, dut_rstn_d;
  logic        dut_start_q, dut_start_d;
  logic        busy_q, busy_d;

  // State register and registered outputs; async reset aborts any run.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      rst_cnt_q   <= '0;
      timer_q     <= '0;
      iter_cnt_q  <= '0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      dut_rstn_q  <= 1'b0;
      dut_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rst_cnt_q   <= rst_cnt_d;
      timer_q     <= timer_d;
      iter_cnt_q  <= iter_cnt_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      timeout_q   <= timeout_d;
      dut_rstn_q  <= dut_rstn_d;
      dut_start_q <= dut_start_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; outputs are decoded from the state being entered so
  // that they line up with the registered state.
  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    timer_d    = timer_q;
    iter_cnt_d = iter_cnt_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_go) begin
          state_d    = S_RESET;
          rst_cnt_d  = '0;
          iter_cnt_d = '0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      S_RESET: begin
        if (rst_cnt_q == C_RST_LAST) begin
          state_d = S_START;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + 16'd1;
        // Error beats done; both beat a timeout landing in the same cycle.
        if (i_dut_err) begin
          fail_d  = 1'b1;
          state_d = S_DONE;
        end else if (i_dut_done) begin
          iter_cnt_d = iter_cnt_q + 8'd1;
          if ((iter_cnt_q + 8'd1) == C_N_ITER) begin
            pass_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            rst_cnt_d = '0;
            state_d   = S_RESET;
          end
        end else if (timer_q == C_TMO_LAST) begin
          fail_d    = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    dut_rstn_d  = (state_d != S_RESET);
    dut_start_d = (state_d == S_START);
    busy_d      = (state_d == S_RESET) || (state_d == S_START) || (state_d == S_WAIT);
  end

  assign o_dut_rstn  = dut_rstn_q;
  assign o_dut_start = dut_start_q;
  assign o_busy      = busy_q;
  assign o_pass      = pass_q;
  assign o_fail      = fail_q;
  assign o_timeout   = timeout_q;
  assign o_iter_cnt  = iter_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_tb_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tb_seq_ctrl
//  Purpose  : Self-checking bench for tb_seq_ctrl. The bench plays the DUT
//             role (answers start pulses with done/err/nothing) and predicts
//             each run's outcome from a per-iteration scenario list.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tb_seq_ctrl;

  localparam int RST_CYC_A = 2;
  localparam int TIMEOUT_A = 8;
  localparam int N_ITER_A  = 4;
  localparam int RST_CYC_B = 3;
  localparam int TIMEOUT_B = 20;

  localparam int K_DONE = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  logic       clk;
  logic       rstn;
  logic       go, done, err;
  logic       dut_rstn, dut_start, busy, pass, fail, tmo;
  logic [7:0] iter_cnt;
  logic       go_b, done_b, err_b;
  logic       dut_rstn_b, dut_start_b, busy_b, pass_b, fail_b, tmo_b;
  logic [7:0] iter_cnt_b;

  int n_checks;
  int n_fail;
  int kind [N_ITER_A];
  int lat  [N_ITER_A];

  tb_seq_ctrl #(.RST_CYC(RST_CYC_A), .TIMEOUT(TIMEOUT_A), .N_ITER(N_ITER_A)) u_dut_a (
    .clk(clk), .rstn(rstn), .i_go(go), .i_dut_done(done), .i_dut_err(err),
    .o_dut_rstn(dut_rstn), .o_dut_start(dut_start), .o_busy(busy),
    .o_pass(pass), .o_fail(fail), .o_timeout(tmo), .o_iter_cnt(iter_cnt)
  );

  tb_seq_ctrl #(.RST_CYC(RST_CYC_B), .TIMEOUT(TIMEOUT_B), .N_ITER(1)) u_dut_b (
    .clk(clk), .rstn(rstn), .i_go(go_b), .i_dut_done(done_b), .i_dut_err(err_b),
    .o_dut_rstn(dut_rstn_b), .o_dut_start(dut_start_b), .o_busy(busy_b),
    .o_pass(pass_b), .o_fail(fail_b), .o_timeout(tmo_b), .o_iter_cnt(iter_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fill the scenario list with one kind and random latencies in lo..hi.
  task automatic fill(input int k, input int lo, input int hi);
    for (int i = 0; i < N_ITER_A; i++) begin
      kind[i] = k;
      lat[i]  = $urandom_range(hi, lo);
    end
  endtask

  // One complete run on instance A following kind[]/lat[]; abort_iter >= 0
  // pulls rstn low during WAIT of that iteration instead of answering.
  task automatic do_run(input string tag, input int abort_iter);
    int exp_cnt, exp_iters, run_cnt, low;
    bit exp_pass, exp_fail, exp_to, seen;
    logic [7:0] h_cnt;
    logic h_p, h_f, h_t;
    // Outcome predicted from the scenario list alone.
    exp_cnt = 0; exp_iters = 0; exp_pass = 0; exp_fail = 0; exp_to = 0;
    for (int i = 0; i < N_ITER_A; i++) begin
      exp_iters++;
      if (kind[i] == K_ERR || kind[i] == K_BOTH) begin exp_fail = 1; break; end
      if (kind[i] == K_NONE) begin exp_fail = 1; exp_to = 1; break; end
      exp_cnt++;
      if (exp_cnt == N_ITER_A) begin exp_pass = 1; break; end
    end

    @(negedge clk); go = 1'b1;
    @(negedge clk); go = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || dut_rstn !== 1'b0 || pass !== 1'b0 || fail !== 1'b0 || tmo !== 1'b0 || iter_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL %s entry: busy=%b dut_rstn=%b pass=%b fail=%b to=%b cnt=%0d, want 1 0 0 0 0 0",
               tag, busy, dut_rstn, pass, fail, tmo, iter_cnt);
    end

    run_cnt = 0;
    for (int i = 0; i < exp_iters; i++) begin
      low  = (dut_rstn === 1'b0) ? 1 : 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (dut_start === 1'b1) seen = 1;
        else if (dut_rstn === 1'b0) low++;
      end
      n_checks++;
      if (!seen || low != RST_CYC_A || dut_rstn !== 1'b1 || iter_cnt !== 8'(run_cnt)) begin
        n_fail++;
        $display("FAIL %s start%0d: seen=%0d low=%0d dut_rstn=%b cnt=%0d, want 1 %0d 1 %0d",
                 tag, i, seen, low, dut_rstn, iter_cnt, RST_CYC_A, run_cnt);
        if (!seen) return;
      end

      if (i == abort_iter) begin
        repeat (2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        n_checks++;
        if (dut_rstn !== 1'b0 || dut_start !== 1'b0 || busy !== 1'b0 || pass !== 1'b0 ||
            fail !== 1'b0 || tmo !== 1'b0 || iter_cnt !== 8'd0) begin
          n_fail++;
          $display("FAIL %s async_rst: rstn=%b start=%b busy=%b pass=%b fail=%b to=%b cnt=%0d, want all 0",
                   tag, dut_rstn, dut_start, busy, pass, fail, tmo, iter_cnt);
        end
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (dut_rstn !== 1'b1 || busy !== 1'b0 || dut_start !== 1'b0 || fail !== 1'b0) begin
          n_fail++;
          $display("FAIL %s post_rst: dut_rstn=%b busy=%b start=%b fail=%b, want 1 0 0 0",
                   tag, dut_rstn, busy, dut_start, fail);
        end
        return;
      end

      if (kind[i] == K_NONE) begin
        repeat (TIMEOUT_A) @(negedge clk);
        n_checks++;
        if (fail !== 1'b0 || busy !== 1'b1) begin
          n_fail++;
          $display("FAIL %s early_timeout: fail=%b busy=%b, want 0 1", tag, fail, busy);
        end
        @(negedge clk);
      end else begin
        repeat (lat[i]) @(negedge clk);
        done = (kind[i] != K_ERR);
        err  = (kind[i] != K_DONE);
        @(negedge clk);
        done = 1'b0; err = 1'b0;
        if (kind[i] == K_DONE) run_cnt++;
        n_checks++;
        if (iter_cnt !== 8'(run_cnt)) begin
          n_fail++;
          $display("FAIL %s cnt%0d: got %0d want %0d", tag, i, iter_cnt, run_cnt);
        end
      end
    end

    n_checks++;
    if (pass !== exp_pass || fail !== exp_fail || tmo !== exp_to || iter_cnt !== 8'(exp_cnt) ||
        busy !== 1'b0 || dut_rstn !== 1'b1) begin
      n_fail++;
      $display("FAIL %s final: pass=%b fail=%b to=%b cnt=%0d busy=%b dut_rstn=%b, want %0d %0d %0d %0d 0 1",
               tag, pass, fail, tmo, iter_cnt, busy, dut_rstn, exp_pass, exp_fail, exp_to, exp_cnt);
    end

    // DONE must hold its results and ignore done/err.
    h_cnt = iter_cnt; h_p = pass; h_f = fail; h_t = tmo;
    for (int c = 0; c < 3; c++) begin
      done = 1'($urandom); err = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (pass !== h_p || fail !== h_f || tmo !== h_t || iter_cnt !== h_cnt || busy !== 1'b0 || dut_start !== 1'b0) begin
        n_fail++;
        $display("FAIL %s hold%0d: pass=%b fail=%b to=%b cnt=%0d busy=%b start=%b, want %b %b %b %0d 0 0",
                 tag, c, pass, fail, tmo, iter_cnt, busy, dut_start, h_p, h_f, h_t, h_cnt);
      end
    end
    done = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut_rstn !== 1'b0 || dut_start !== 1'b0 || busy !== 1'b0 || pass !== 1'b0 ||
        fail !== 1'b0 || tmo !== 1'b0 || iter_cnt !== 8'd0 || dut_rstn_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_vals: rstn=%b start=%b busy=%b pass=%b fail=%b to=%b cnt=%0d rstn_b=%b, want all 0",
               dut_rstn, dut_start, busy, pass, fail, tmo, iter_cnt, dut_rstn_b);
    end
    rstn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (dut_rstn !== 1'b1 || busy !== 1'b0 || dut_rstn_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: dut_rstn=%b busy=%b rstn_b=%b, want 1 0 1", dut_rstn, busy, dut_rstn_b);
    end
    // Done/err in IDLE must not start anything.
    done = 1'b1; err = 1'b1;
    repeat (2) @(negedge clk);
    done = 1'b0; err = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || fail !== 1'b0 || iter_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL idle_ignore: busy=%b fail=%b cnt=%0d, want 0 0 0", busy, fail, iter_cnt);
    end
  endtask

  task automatic test_pass();
    fill(K_DONE, 5, 5);
    do_run("pass_lat5", -1);
    fill(K_DONE, 1, TIMEOUT_A);
    do_run("pass_rand", -1);
    fill(K_DONE, TIMEOUT_A, TIMEOUT_A);
    do_run("pass_at_timeout_edge", -1);
  endtask

  task automatic test_error();
    fill(K_DONE, 1, TIMEOUT_A);
    kind[1] = K_ERR;
    do_run("err_iter2", -1);
    kind[1] = K_ERR; lat[1] = TIMEOUT_A;
    do_run("err_at_timeout_edge", -1);
  endtask

  task automatic test_timeout();
    fill(K_DONE, 1, TIMEOUT_A);
    kind[0] = K_NONE;
    do_run("timeout_iter1", -1);
    fill(K_DONE, 1, TIMEOUT_A);
    kind[2] = K_NONE;
    do_run("timeout_iter3", -1);
  endtask

  task automatic test_both();
    fill(K_DONE, 1, TIMEOUT_A);
    kind[$urandom_range(N_ITER_A - 1, 0)] = K_BOTH;
    do_run("done_and_err", -1);
  endtask

  task automatic test_async_reset();
    fill(K_DONE, 3, 6);
    do_run("abort_iter3", 2);
    fill(K_DONE, 1, TIMEOUT_A);
    do_run("after_abort", -1);
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < N_ITER_A; i++) begin
        r = $urandom_range(9, 0);
        kind[i] = (r < 6) ? K_DONE : (r < 8) ? K_ERR : (r < 9) ? K_BOTH : K_NONE;
        lat[i]  = $urandom_range(TIMEOUT_A, 1);
      end
      do_run("random", -1);
    end
  endtask

  // Single-iteration instance, run twice so the second run starts from DONE.
  task automatic test_n_iter1();
    int low, starts, l;
    bit seen;
    for (int r = 0; r < 2; r++) begin
      @(negedge clk); go_b = 1'b1;
      @(negedge clk); go_b = 1'b0;
      n_checks++;
      if (busy_b !== 1'b1 || pass_b !== 1'b0 || fail_b !== 1'b0 || iter_cnt_b !== 8'd0) begin
        n_fail++;
        $display("FAIL n1_entry%0d: busy=%b pass=%b fail=%b cnt=%0d, want 1 0 0 0", r, busy_b, pass_b, fail_b, iter_cnt_b);
      end
      low = (dut_rstn_b === 1'b0) ? 1 : 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
        @(negedge clk);
        if (dut_start_b === 1'b1) seen = 1;
        else if (dut_rstn_b === 1'b0) low++;
      end
      n_checks++;
      if (!seen || low != RST_CYC_B) begin
        n_fail++;
        $display("FAIL n1_start%0d: seen=%0d low=%0d, want 1 %0d", r, seen, low, RST_CYC_B);
      end
      l = $urandom_range(TIMEOUT_B, 1);
      repeat (l) @(negedge clk);
      done_b = 1'b1;
      @(negedge clk);
      done_b = 1'b0;
      n_checks++;
      if (pass_b !== 1'b1 || fail_b !== 1'b0 || tmo_b !== 1'b0 || iter_cnt_b !== 8'd1 || busy_b !== 1'b0) begin
        n_fail++;
        $display("FAIL n1_final%0d: pass=%b fail=%b to=%b cnt=%0d busy=%b, want 1 0 0 1 0",
                 r, pass_b, fail_b, tmo_b, iter_cnt_b, busy_b);
      end
      starts = 0;
      repeat (5) begin
        @(negedge clk);
        if (dut_start_b === 1'b1) starts++;
      end
      n_checks++;
      if (starts != 0 || pass_b !== 1'b1) begin
        n_fail++;
        $display("FAIL n1_single_start%0d: extra_starts=%0d pass=%b, want 0 1", r, starts, pass_b);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rstn = 1'b0; go = 1'b0; done = 1'b0; err = 1'b0;
    go_b = 1'b0; done_b = 1'b0; err_b = 1'b0;
    test_reset();
    test_pass();
    test_error();
    test_timeout();
    test_both();
    test_async_reset();
    test_random();
    test_n_iter1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
